dm_ctrl: RTL

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_pkg.sv | 75 +++++++
 rtl/dm_lane_mem.sv | 45 ++++
 rtl/dm_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_pkg : size/state encodings and lane helper functions for dm_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int c_CNT_W = 2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [31:0] word, input logic [1:0] lo);
    logic [31:0] sh;
    logic [31:0] d;
    sh = word >> {lo, 3'b000};
    d  = 32'h0;
    case (size)
      SZ_BYTE: d = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: d = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: d = word;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_lane_mem : word array with per-byte write lanes and extended lane read
// Revision: 1.0
// ---------------------------------------------------------------------------
module dm_lane_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int c_DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0]       r_mem [c_DEPTH];
  logic [3:0]        w_be;
  logic [31:0]       w_lanes;
  logic [ADDR_W-3:0] w_idx;
  logic [31:0]       w_word;

  assign w_idx   = addr[ADDR_W-1:2];
  assign w_be    = wr_en ? byte_en(size, addr[1:0]) : 4'b0000;
  assign w_lanes = lane_wdata(size, wdata);

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign rdata  = load_extend(size, uns, w_word, addr[1:0]);

endmodule
`default_nettype wire

// File: rtl/dm_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_ctrl : single-outstanding data-memory controller with fixed read latency
// Revision: 1.0
// ---------------------------------------------------------------------------
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(RD_LAT - 1);

  state_e             r_state;
  state_e             w_state_n;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_n;

  logic               r_we;
  logic [1:0]         r_size;
  logic               r_uns;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;

  logic               w_accept;
  logic               w_err;
  logic               w_wr_en;
  logic [31:0]        w_ld_data;
  logic               w_unused;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_err     = misaligned(req_size, req_addr[1:0]);
  assign w_wr_en   = w_accept & req_we & ~w_err;

  dm_lane_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .wr_en (w_wr_en),
    .size  (req_size),
    .uns   (req_unsigned),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (w_ld_data)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_n   = c_LAT_M1;
          w_state_n = (RD_LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leave WAIT as the counter reaches zero so RESP lands RD_LAT cycles after accept.
        w_cnt_n = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        if (r_cnt <= c_CNT_W'(1)) begin
          w_state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= (req_we | w_err) ? 32'h0 : w_ld_data;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = misaligned(r_size, r_addr[1:0]);

  // Latched request fields kept for observability but not needed by the datapath.
  assign w_unused = ^{r_we, r_uns, r_wdata, r_addr[ADDR_W-1:2]};

endmodule
`default_nettype wire
